// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared types and default sizing for the multi-channel
// dispatch stage (dispatch_multi and its per-channel queue disp_chan_fifo).
//
// Contents:
//   DEF_*           default parameter values used by dispatch_multi
//   chanId_t        channel identifier at default NUM_CH
//   dispPayload_t   per-instruction queue payload at default width
//   exceptCause_t   frontend exception cause at default width
//   chan_e          well-known channel IDs (INT_CH, MEM_CH, FP_CH)
package dispatch_pkg;

  localparam int DEF_IN_WID    = 4;
  localparam int DEF_NUM_CH    = 3;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_OUT_WID   = 2;
  localparam int DEF_PAYLOAD_W = 64;
  localparam int DEF_ROBIDX_W  = 7;
  localparam int DEF_EXC_W     = 5;

  localparam int DEF_CH_W = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;

  typedef logic [DEF_CH_W-1:0]      chanId_t;
  typedef logic [DEF_PAYLOAD_W-1:0] dispPayload_t;
  typedef logic [DEF_EXC_W-1:0]     exceptCause_t;

  typedef enum logic [DEF_CH_W-1:0] {
    INT_CH = 2'd0,
    MEM_CH = 2'd1,
    FP_CH  = 2'd2
  } chan_e;

endpackage

// File: rtl/disp_chan_fifo.sv
// disp_chan_fifo: one dispatch channel queue. Accepts up to IN_WID writes per
// cycle (any subset of slots, packed at the tail in slot order) and presents
// up to OUT_WID oldest entries per cycle. Pointers carry a wrap bit, so the
// occupancy is simply tail - head and full is "equal index, wrap differs".
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           empties the queue; overrides enqueue and pop this cycle
//   enq_vld         per-slot write enable (caller guarantees space)
//   enq_data        per-slot payloads, slot 0 in the low bits
//   deq_pop         pop every entry presented on deq_vld at the clock edge
//   deq_vld         min(count, OUT_WID) lowest bits set
//   deq_data        oldest-first payloads, zero where not valid
//   count           registered occupancy, 0..DEPTH
module disp_chan_fifo #(
  parameter int IN_WID    = 4,
  parameter int OUT_WID   = 2,
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 64,
  localparam int PTR_W    = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [IN_WID-1:0]            enq_vld,
  input  logic [IN_WID*PAYLOAD_W-1:0]  enq_data,
  input  logic                         deq_pop,
  output logic [OUT_WID-1:0]           deq_vld,
  output logic [OUT_WID*PAYLOAD_W-1:0] deq_data,
  output logic [PTR_W-1:0]             count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]     head_reg, tail_reg;
  logic [PTR_W-1:0]     head_next, tail_next;
  logic [PTR_W-1:0]     enq_cnt, deq_cnt;
  logic [IDX_W-1:0]     wr_idx [IN_WID];

  assign count = tail_reg - head_reg;

  // Each written slot lands at tail + (number of written slots before it),
  // so sparse enable patterns still pack contiguously.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < IN_WID; i++) begin
      wr_idx[i] = tail_reg[IDX_W-1:0] + enq_cnt[IDX_W-1:0];
      if (enq_vld[i]) begin
        enq_cnt = enq_cnt + PTR_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < OUT_WID; gi++) begin : g_deq
    logic [IDX_W-1:0] rd_idx;
    assign rd_idx      = head_reg[IDX_W-1:0] + IDX_W'(gi);
    assign deq_vld[gi] = (count > PTR_W'(gi));
    assign deq_data[gi*PAYLOAD_W +: PAYLOAD_W] = deq_vld[gi] ? mem_reg[rd_idx] : '0;
  end

  always_comb begin
    deq_cnt = '0;
    if (deq_pop) begin
      deq_cnt = (count < PTR_W'(OUT_WID)) ? count : PTR_W'(OUT_WID);
    end
    head_next = head_reg + deq_cnt;
    tail_next = tail_reg + enq_cnt;
    if (flush) begin
      head_next = '0;
      tail_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  // Storage is not reset: unread contents are masked by deq_vld.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WID; i++) begin
      if (enq_vld[i] && !flush) begin
        mem_reg[wr_idx[i]] <= enq_data[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

endmodule

// File: rtl/dispatch_multi.sv
// dispatch_multi: routes up to IN_WID renamed instructions per cycle into
// NUM_CH dispatch queues in program order. A prefix of the offered slots is
// accepted each cycle; accepted slots also leave as ROB-insert requests.
// An accepted excepting slot goes to the ROB only and ends the prefix; its
// ROB index and cause are written back one cycle later.
//
// Optional build macro: DISPATCH_PERF_CNT_EN adds saturating 32-bit counters
// of cycles blocked by each channel's capacity (o_perf_chan_full) and by ROB
// space (o_perf_rob_block); they are cleared by reset only.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   i_flush              squash: empty queues, drop pending exception
//   i_enq_vld            slot valid, contiguous from slot 0
//   i_enq_ch             target channel per slot
//   i_enq_data           queue payload per slot
//   i_enq_has_except     frontend exception on slot
//   i_enq_except         exception cause per slot
//   i_alloc_robIdx       ROB index per slot
//   i_rob_free           ROB entries available this cycle
//   o_enq_accept         accepted slot prefix
//   o_rob_insert_req     same as o_enq_accept
//   o_exceptwb_vld       registered exception writeback pulse
//   o_exceptwb_robIdx    ROB index of the accepted excepting slot
//   o_exceptwb_cause     its cause
//   i_deq_stall          per-channel consumer stall
//   o_deq_vld            per-channel valid mask, contiguous from bit 0
//   o_deq_data           per-channel oldest-first payloads
module dispatch_multi
  import dispatch_pkg::*;
#(
  parameter int IN_WID    = DEF_IN_WID,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int OUT_WID   = DEF_OUT_WID,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int ROBIDX_W  = DEF_ROBIDX_W,
  parameter int EXC_W     = DEF_EXC_W,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int RF_W     = $clog2(IN_WID + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_flush,
  input  logic [IN_WID-1:0]                   i_enq_vld,
  input  logic [IN_WID*CH_W-1:0]              i_enq_ch,
  input  logic [IN_WID*PAYLOAD_W-1:0]         i_enq_data,
  input  logic [IN_WID-1:0]                   i_enq_has_except,
  input  logic [IN_WID*EXC_W-1:0]             i_enq_except,
  input  logic [IN_WID*ROBIDX_W-1:0]          i_alloc_robIdx,
  input  logic [RF_W-1:0]                     i_rob_free,
  output logic [IN_WID-1:0]                   o_enq_accept,
  output logic [IN_WID-1:0]                   o_rob_insert_req,
  output logic                                o_exceptwb_vld,
  output logic [ROBIDX_W-1:0]                 o_exceptwb_robIdx,
  output logic [EXC_W-1:0]                    o_exceptwb_cause,
  input  logic [NUM_CH-1:0]                   i_deq_stall,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [NUM_CH*32-1:0]                o_perf_chan_full,
  output logic [31:0]                         o_perf_rob_block,
`endif
  output logic [NUM_CH*OUT_WID-1:0]           o_deq_vld,
  output logic [NUM_CH*OUT_WID*PAYLOAD_W-1:0] o_deq_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CH_W-1:0]     slot_ch  [IN_WID];
  logic [CNT_W-1:0]    ch_count [NUM_CH];
  logic [IN_WID-1:0]   reach;     // every older slot accepted and non-excepting
  logic [IN_WID-1:0]   fits;      // channel space covers cumulative demand
  logic [IN_WID-1:0]   rob_ok;    // ROB has room for slots 0..k
  logic [IN_WID-1:0]   accept;
  logic [IN_WID-1:0]   enq_mask;  // accepted and actually written to a queue

  logic                exc_hit;
  logic [ROBIDX_W-1:0] exc_rob;
  logic [EXC_W-1:0]    exc_cause;
  logic                exc_vld_reg;
  logic [ROBIDX_W-1:0] exc_rob_reg;
  logic [EXC_W-1:0]    exc_cause_reg;

  for (genvar gi = 0; gi < IN_WID; gi++) begin : g_slot
    assign slot_ch[gi] = i_enq_ch[gi*CH_W +: CH_W];
  end

  // Capacity uses registered occupancy only; a same-cycle pop frees nothing
  // until the next cycle. Excepting slots are never written, so they do not
  // add to any channel's demand.
  always_comb begin : accept_logic
    int  demand [NUM_CH];
    logic chain_ok;
    for (int c = 0; c < NUM_CH; c++) begin
      demand[c] = 0;
    end
    chain_ok = !i_flush;
    reach    = '0;
    fits     = '1;
    rob_ok   = '0;
    accept   = '0;
    enq_mask = '0;
    for (int k = 0; k < IN_WID; k++) begin
      rob_ok[k] = ((k + 1) <= int'(i_rob_free));
      if (!i_enq_has_except[k]) begin
        if (int'(slot_ch[k]) >= NUM_CH) begin
          fits[k] = 1'b0;
        end else begin
          demand[slot_ch[k]] = demand[slot_ch[k]] + 1;
          if (demand[slot_ch[k]] > DEPTH - int'(ch_count[slot_ch[k]])) begin
            fits[k] = 1'b0;
          end
        end
      end
      reach[k]    = chain_ok && i_enq_vld[k];
      accept[k]   = reach[k] && rob_ok[k] && fits[k];
      enq_mask[k] = accept[k] && !i_enq_has_except[k];
      chain_ok    = enq_mask[k];
    end
  end

  assign o_enq_accept     = accept;
  assign o_rob_insert_req = accept;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic [IN_WID-1:0] chan_enq;
    always_comb begin
      chan_enq = '0;
      for (int k = 0; k < IN_WID; k++) begin
        chan_enq[k] = enq_mask[k] && (int'(slot_ch[k]) == gi);
      end
    end

    disp_chan_fifo #(
      .IN_WID    (IN_WID),
      .OUT_WID   (OUT_WID),
      .DEPTH     (DEPTH),
      .PAYLOAD_W (PAYLOAD_W)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (i_flush),
      .enq_vld  (chan_enq),
      .enq_data (i_enq_data),
      .deq_pop  (!i_deq_stall[gi]),
      .deq_vld  (o_deq_vld[gi*OUT_WID +: OUT_WID]),
      .deq_data (o_deq_data[gi*OUT_WID*PAYLOAD_W +: OUT_WID*PAYLOAD_W]),
      .count    (ch_count[gi])
    );
  end

  // Scan from the top so the lowest accepted excepting slot wins (the
  // prefix rule already allows at most one).
  always_comb begin
    exc_hit   = 1'b0;
    exc_rob   = '0;
    exc_cause = '0;
    for (int k = IN_WID - 1; k >= 0; k--) begin
      if (accept[k] && i_enq_has_except[k]) begin
        exc_hit   = 1'b1;
        exc_rob   = i_alloc_robIdx[k*ROBIDX_W +: ROBIDX_W];
        exc_cause = i_enq_except[k*EXC_W +: EXC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_vld_reg   <= 1'b0;
      exc_rob_reg   <= '0;
      exc_cause_reg <= '0;
    end else begin
      exc_vld_reg <= exc_hit && !i_flush;
      if (exc_hit && !i_flush) begin
        exc_rob_reg   <= exc_rob;
        exc_cause_reg <= exc_cause;
      end
    end
  end

  assign o_exceptwb_vld    = exc_vld_reg;
  assign o_exceptwb_robIdx = exc_rob_reg;
  assign o_exceptwb_cause  = exc_cause_reg;

`ifdef DISPATCH_PERF_CNT_EN
  // A cycle counts against a channel when the first slot that failed to be
  // accepted was refused for that channel's space.
  logic [NUM_CH-1:0] chan_blocked;
  logic [31:0]       perf_rob_reg;

  always_comb begin
    chan_blocked = '0;
    for (int k = 0; k < IN_WID; k++) begin
      if (reach[k] && !fits[k] && (int'(slot_ch[k]) < NUM_CH)) begin
        chan_blocked[slot_ch[k]] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_perf
    logic [31:0] cnt_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (chan_blocked[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
    assign o_perf_chan_full[gi*32 +: 32] = cnt_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_rob_reg <= '0;
    end else if ((|(reach & ~rob_ok)) && (perf_rob_reg != '1)) begin
      perf_rob_reg <= perf_rob_reg + 32'd1;
    end
  end

  assign o_perf_rob_block = perf_rob_reg;
`endif

endmodule

// File: doc/dispatch_multi.md
Name: dispatch_multi

Overview:
- Parametrised successor to the single-int-queue dispatch stage: routes up to IN_WID renamed instructions per cycle into NUM_CH independent dispatch queues (int/mem/fp/...), in program order.
- Supports partial (prefix) dispatch instead of all-or-nothing stall.
- Per-channel dequeue with independent stall; one-cycle-delayed frontend exception writeback.
- Sits between rename and the issue blocks; ROB-insert requests leave in parallel.

Parameters:
- IN_WID, 4, instructions offered per cycle from rename
- NUM_CH, 3, number of dispatch queues/channels
- DEPTH, 16, entries per channel queue (power of 2, >= IN_WID)
- OUT_WID, 2, max dequeues per channel per cycle
- PAYLOAD_W, 64, width of per-instruction queue payload
- ROBIDX_W, 7, ROB index width
- EXC_W, 5, exception-cause width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- i_flush  input  1  squash: empty all queues, drop pending exception
- i_enq_vld  input  IN_WID  slot valid, contiguous from slot 0
- i_enq_ch  input  IN_WID*clog2(NUM_CH)  target channel per slot
- i_enq_data  input  IN_WID*PAYLOAD_W  queue payload per slot
- i_enq_has_except  input  IN_WID  frontend/decode exception on slot
- i_enq_except  input  IN_WID*EXC_W  exception cause
- i_alloc_robIdx  input  IN_WID*ROBIDX_W  ROB index per slot
- i_rob_free  input  clog2(IN_WID+1)  ROB entries available this cycle
- o_enq_accept  output  IN_WID  accepted slots (prefix); rename retires these
- o_rob_insert_req  output  IN_WID  equals o_enq_accept
- o_exceptwb_vld  output  1  registered exception writeback
- o_exceptwb_robIdx  output  ROBIDX_W  ROB index of oldest accepted excepting slot
- o_exceptwb_cause  output  EXC_W  its cause
- o_deq_vld  output  NUM_CH*OUT_WID  per-channel valid mask, contiguous from 0
- o_deq_data  output  NUM_CH*OUT_WID*PAYLOAD_W  per-channel oldest-first payloads
- i_deq_stall  input  NUM_CH  channel consumer stalled; no pop

Behaviour:
- Reset (async assert, rst=0): all pointers/counts 0, o_deq_vld=0, o_exceptwb_vld=0, o_enq_accept=0 (combinational from empty state with i_rob_free forced irrelevant as queues read empty, accept still requires valid). All other outputs 0.
- Accept: slot k is accepted iff slots 0..k are all valid, k+1 <= i_rob_free, every slot in 0..k fits its channel (per-channel cumulative demand <= DEPTH - count, using registered count only, no same-cycle dequeue credit), and no slot j<k has an exception.
- An excepting slot may itself be accepted (goes to ROB only, never enqueued); slots after it are not accepted that cycle.
- Enqueue writes accepted non-excepting slots at tail in slot order; tail += count. Pointers carry a wrap bit; full = ptrs equal with wrap differing.
- Dequeue: o_deq_vld[ch] = min(count, OUT_WID) lowest bits set, data oldest-first. If !i_deq_stall[ch], all presented entries pop at the clock edge. Enqueued entries are visible at the dequeue port the next cycle (1-cycle latency).
- Simultaneous enq/deq on a channel: count_next = count + enq - deq. Full and empty transitions are both legal in the same cycle.
- Exception: at the edge, o_exceptwb_vld <= any accepted excepting slot; robIdx/cause latched from the lowest such slot; otherwise vld cleared next cycle (pulse).
- Flush has priority: o_enq_accept=0 and no dequeue pop that cycle; next cycle all counts 0 and o_exceptwb_vld=0. Flush overrides a same-cycle exception.
- Async reset mid-operation discards all state immediately.

Optional Feature:
- DISPATCH_PERF_CNT_EN: adds per-channel 32-bit saturating counters for cycles with a valid slot blocked by that channel's capacity, plus a ROB-blocked counter. Exposed on o_perf_chan_full[NUM_CH*32] and o_perf_rob_block[32]; cleared by reset only, not by flush.
- Without the macro: ports and counters are absent; functionality is otherwise identical.

Decomposition:
- dispatch_pkg holds: chanId_t, dispPayload_t, exceptCause_t, channel ID constants (INT_CH, MEM_CH, FP_CH), and default parameter constants.
- Sub-module disp_chan_fifo: multi-in (IN_WID) / multi-out (OUT_WID) circular FIFO with flush, count output, wrap-bit pointers. Instantiated NUM_CH times via generate.
- Top level holds the prefix-accept logic and the exception register.

Test Plan:
- 4 valid slots to ch0/1/2/0, i_rob_free=4, queues empty → o_enq_accept=4'b1111; next cycle o_deq_vld ch0=2'b11, ch1=2'b01, ch2=2'b01.
- ch0 count=15, slots to ch0,ch0,ch1 → accept=3'b001; ch0 full; slots 1-2 re-offered next cycle.
- i_rob_free=2 with 4 valid slots → accept=4'b0011.
- Slot1 has_except cause 2, robIdx 9 → accept=4'b0011, slot1 not enqueued; next cycle o_exceptwb_vld=1, robIdx=9, cause=2; following cycle vld=0.
- ch1 holds 3 entries, i_deq_stall[1]=1 for 2 cycles then 0 → o_deq_vld[ch1]=2'b11 held with data unchanged, then pops 2, leaving 1.
- i_flush with full queues and a same-cycle exception → accept=0; next cycle all o_deq_vld=0 and o_exceptwb_vld=0.
